// File: rtl/mc14500_pkg.sv
// Shared opcode definitions for the MC14500-compatible 1-bit ICU.
package mc14500_pkg;

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_e;

    localparam logic [3:0] IR_RESET = 4'hF;

endpackage

// File: rtl/caravel_mc14500_if.sv
// Pin bundle of the ICU. master = instruction/data source, slave = the ICU.
// Optional ir[3:0] exists only when MC14500_IR_OUT_EN is defined.
interface caravel_mc14500_if;
    // instr/data_in are sampled on each rising clk edge; there is no valid/ready
    // pair: every rising edge executes exactly one opcode.
    logic [3:0] instr;
    logic       data_in;
    logic       data_out;
    logic       write;
    logic       rr;
    logic       jmp;
    logic       rtn;
    logic       flag_o;
    logic       flag_f;
`ifdef MC14500_IR_OUT_EN
    logic [3:0] ir;

    modport master (output instr, data_in,
                    input  data_out, write, rr, jmp, rtn, flag_o, flag_f, ir);
    modport slave  (input  instr, data_in,
                    output data_out, write, rr, jmp, rtn, flag_o, flag_f, ir);
`else
    modport master (output instr, data_in,
                    input  data_out, write, rr, jmp, rtn, flag_o, flag_f);
    modport slave  (input  instr, data_in,
                    output data_out, write, rr, jmp, rtn, flag_o, flag_f);
`endif
endinterface

// File: rtl/mc14500_lu.sv
// Combinational logic unit: next result register value and store data.
module mc14500_lu
    import mc14500_pkg::*;
(
    input  opcode_e i_op,
    input  logic    i_rr,
    input  logic    i_d,
    output logic    o_rr_next,
    output logic    o_data_out
);

    always_comb begin
        o_rr_next  = i_rr;
        o_data_out = i_rr;
        case (i_op)
            OP_LD:   o_rr_next  = i_d;
            OP_LDC:  o_rr_next  = ~i_d;
            OP_AND:  o_rr_next  = i_rr & i_d;
            OP_ANDC: o_rr_next  = i_rr & ~i_d;
            OP_OR:   o_rr_next  = i_rr | i_d;
            OP_ORC:  o_rr_next  = i_rr | ~i_d;
            OP_XNOR: o_rr_next  = ~(i_rr ^ i_d);
            OP_STOC: o_data_out = ~i_rr;
            default: o_rr_next  = i_rr;
        endcase
    end

endmodule

// File: rtl/caravel_mc14500.sv
// MC14500-compatible 1-bit industrial control unit, one opcode per rising edge.
// Optional feature macro: MC14500_IR_OUT_EN (adds ir output of last executed opcode).
module caravel_mc14500
    import mc14500_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    caravel_mc14500_if.slave        bus
);

    opcode_e w_op;
    logic    w_exec;
    logic    w_d;
    logic    w_rr_next;
    logic    w_lu_dout;
    logic    w_store;

    logic    r_rr;
    logic    r_ien;
    logic    r_oen;
    logic    r_skip;
    logic    r_jmp;
    logic    r_rtn;
    logic    r_flag_o;
    logic    r_flag_f;
    logic    r_write;
    logic    r_data_out;

    assign w_op    = opcode_e'(bus.instr);
    // A pending skip turns the fetched opcode into a silent NOP.
    assign w_exec  = ~r_skip;
    assign w_d     = bus.data_in & r_ien;
    assign w_store = (w_op == OP_STO) || (w_op == OP_STOC);

    mc14500_lu u_lu (
        .i_op       (w_op),
        .i_rr       (r_rr),
        .i_d        (w_d),
        .o_rr_next  (w_rr_next),
        .o_data_out (w_lu_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr       <= 1'b0;
            r_ien      <= 1'b0;
            r_oen      <= 1'b0;
            r_skip     <= 1'b0;
            r_jmp      <= 1'b0;
            r_rtn      <= 1'b0;
            r_flag_o   <= 1'b0;
            r_flag_f   <= 1'b0;
            r_write    <= 1'b0;
            r_data_out <= 1'b0;
        end else begin
            r_skip   <= w_exec && ((w_op == OP_RTN) || ((w_op == OP_SKZ) && !r_rr));
            r_jmp    <= w_exec && (w_op == OP_JMP);
            r_rtn    <= w_exec && (w_op == OP_RTN);
            r_flag_o <= w_exec && (w_op == OP_NOPO);
            r_flag_f <= w_exec && (w_op == OP_NOPF);
            r_write  <= w_exec && r_oen && w_store;
            if (w_exec) begin
                r_rr <= w_rr_next;
                if (w_op == OP_IEN) r_ien <= bus.data_in;
                if (w_op == OP_OEN) r_oen <= bus.data_in;
                if (w_store && r_oen) r_data_out <= w_lu_dout;
            end
        end
    end

`ifdef MC14500_IR_OUT_EN
    logic [3:0] r_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ir <= IR_RESET;
        else if (w_exec) r_ir <= bus.instr;
    end

    assign bus.ir = r_ir;
`endif

    // The store strobe is confined to the high phase of the execute cycle.
    assign bus.write    = r_write & clk;
    assign bus.data_out = r_data_out;
    assign bus.rr       = r_rr;
    assign bus.jmp      = r_jmp;
    assign bus.rtn      = r_rtn;
    assign bus.flag_o   = r_flag_o;
    assign bus.flag_f   = r_flag_f;

endmodule

// File: tb/tb_caravel_mc14500.sv
// Self-checking bench for caravel_mc14500: directed scenarios plus random opcodes
// checked against a per-instruction behavioural model.
module tb_caravel_mc14500;
    import mc14500_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    caravel_mc14500_if bus_if ();

    caravel_mc14500 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic       m_rr, m_ien, m_oen, m_skip;
    logic       e_jmp, e_rtn, e_fo, e_ff, e_write, e_dout;
    logic [3:0] m_ir;

    task automatic model_reset();
        m_rr = 0; m_ien = 0; m_oen = 0; m_skip = 0;
        e_jmp = 0; e_rtn = 0; e_fo = 0; e_ff = 0; e_write = 0; e_dout = 0;
        m_ir = 4'hF;
    endtask

    // ---------------- driver ----------------
    // Called in the low phase; returns 1 time unit after the execute edge.
    task automatic step(input logic [3:0] op, input logic din);
        logic d;
        bus_if.instr   = op;
        bus_if.data_in = din;
        @(posedge clk);
        #1;
        e_jmp = 0; e_rtn = 0; e_fo = 0; e_ff = 0; e_write = 0;
        if (m_skip) begin
            m_skip = 0;
        end else begin
            d = din & m_ien;
            case (op)
                OP_NOPO: e_fo = 1;
                OP_LD:   m_rr = d;
                OP_LDC:  m_rr = !d;
                OP_AND:  m_rr = m_rr && d;
                OP_ANDC: m_rr = m_rr && !d;
                OP_OR:   m_rr = m_rr || d;
                OP_ORC:  m_rr = m_rr || !d;
                OP_XNOR: m_rr = (m_rr == d);
                OP_STO:  if (m_oen) begin e_write = 1; e_dout = m_rr; end
                OP_STOC: if (m_oen) begin e_write = 1; e_dout = !m_rr; end
                OP_IEN:  m_ien = din;
                OP_OEN:  m_oen = din;
                OP_JMP:  e_jmp = 1;
                OP_RTN:  begin e_rtn = 1; m_skip = 1; end
                OP_SKZ:  if (m_rr == 0) m_skip = 1;
                default: e_ff = 1;
            endcase
            m_ir = op;
        end
    endtask

    task automatic to_low();
        @(negedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0;
        bus_if.instr = 4'h0;
        bus_if.data_in = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus_if.rr, bus_if.jmp, bus_if.rtn, bus_if.flag_o, bus_if.flag_f, bus_if.write, bus_if.data_out} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {bus_if.rr, bus_if.jmp, bus_if.rtn, bus_if.flag_o, bus_if.flag_f, bus_if.write, bus_if.data_out});
        end
`ifdef MC14500_IR_OUT_EN
        checks++;
        if (bus_if.ir !== 4'hF) begin
            failures++;
            $display("FAIL reset_ir: got %h required f", bus_if.ir);
        end
`endif
        rst_n = 1;
        step(OP_NOPO, 0);
        checks++;
        if (bus_if.flag_o !== 1'b1 || bus_if.flag_f !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_nopo: got flag_o=%b flag_f=%b required 1 0", bus_if.flag_o, bus_if.flag_f);
        end
        to_low();
        step(OP_NOPF, 0);
        checks++;
        if (bus_if.flag_o !== 1'b0 || bus_if.flag_f !== 1'b1) begin
            failures++;
            $display("FAIL reset_then_nopf: got flag_o=%b flag_f=%b required 0 1", bus_if.flag_o, bus_if.flag_f);
        end
        to_low();
    endtask

    task automatic test_logic();
        logic [3:0] ops [10]  = '{OP_LD, OP_LD, OP_LDC, OP_LD, OP_ORC, OP_LD, OP_ANDC, OP_XNOR, OP_XNOR, OP_XNOR};
        logic       dins[10]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0, 0};
        logic       exps[10]  = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 0};
        step(OP_IEN, 1); to_low();
        step(OP_OEN, 1); to_low();
        for (int i = 0; i < 10; i++) begin
            step(ops[i], dins[i]);
            checks++;
            if (bus_if.rr !== exps[i]) begin
                failures++;
                $display("FAIL logic_op[%0d] op=%h din=%b: got rr=%b required %b", i, ops[i], dins[i], bus_if.rr, exps[i]);
            end
            to_low();
        end
        // XNOR from RR=1: data 1 keeps 1, data 0 gives 0, data 0 again gives 1
        step(OP_LD, 1); to_low();
        step(OP_XNOR, 1);
        checks++;
        if (bus_if.rr !== 1'b1) begin failures++; $display("FAIL xnor_11: got rr=%b required 1", bus_if.rr); end
        to_low();
        step(OP_XNOR, 0);
        checks++;
        if (bus_if.rr !== 1'b0) begin failures++; $display("FAIL xnor_10: got rr=%b required 0", bus_if.rr); end
        to_low();
        step(OP_XNOR, 0);
        checks++;
        if (bus_if.rr !== 1'b1) begin failures++; $display("FAIL xnor_00: got rr=%b required 1", bus_if.rr); end
        to_low();
    endtask

    task automatic test_store();
        step(OP_LD, 1); to_low();
        step(OP_STO, 0);
        checks++;
        if (bus_if.write !== 1'b1 || bus_if.data_out !== 1'b1 || bus_if.rr !== 1'b1) begin
            failures++;
            $display("FAIL sto_high: got write=%b data_out=%b rr=%b required 1 1 1", bus_if.write, bus_if.data_out, bus_if.rr);
        end
        to_low();
        checks++;
        if (bus_if.write !== 1'b0) begin failures++; $display("FAIL sto_low_phase: got write=%b required 0", bus_if.write); end
        step(OP_LD, 0); to_low();
        step(OP_STOC, 0);
        checks++;
        if (bus_if.write !== 1'b1 || bus_if.data_out !== 1'b1) begin
            failures++;
            $display("FAIL stoc_high: got write=%b data_out=%b required 1 1", bus_if.write, bus_if.data_out);
        end
        to_low();
    endtask

    task automatic test_branch();
        step(OP_JMP, 0);
        checks++;
        if (bus_if.jmp !== 1'b1) begin failures++; $display("FAIL jmp_strobe: got jmp=%b required 1", bus_if.jmp); end
        to_low();
        step(OP_RTN, 0);
        checks++;
        if (bus_if.jmp !== 1'b0 || bus_if.rtn !== 1'b1) begin
            failures++;
            $display("FAIL rtn_strobe: got jmp=%b rtn=%b required 0 1", bus_if.jmp, bus_if.rtn);
        end
        to_low();
        step(OP_NOPF, 0);
        checks++;
        if (bus_if.flag_f !== 1'b0 || bus_if.rtn !== 1'b0) begin
            failures++;
            $display("FAIL rtn_skips_next: got flag_f=%b rtn=%b required 0 0", bus_if.flag_f, bus_if.rtn);
        end
        to_low();
    endtask

    task automatic test_skip();
        step(OP_LD, 1); to_low();
        step(OP_SKZ, 0); to_low();
        step(OP_NOPF, 0);
        checks++;
        if (bus_if.flag_f !== 1'b1) begin failures++; $display("FAIL skz_rr1: got flag_f=%b required 1", bus_if.flag_f); end
        to_low();
        step(OP_LD, 0); to_low();
        step(OP_SKZ, 0); to_low();
        step(OP_NOPF, 0);
        checks++;
        if (bus_if.flag_f !== 1'b0) begin failures++; $display("FAIL skz_rr0: got flag_f=%b required 0", bus_if.flag_f); end
        to_low();
        step(OP_NOPF, 0);
        checks++;
        if (bus_if.flag_f !== 1'b1) begin failures++; $display("FAIL skip_cleared: got flag_f=%b required 1", bus_if.flag_f); end
        to_low();
    endtask

    task automatic test_back_to_back();
        step(OP_JMP, 0); to_low();
        checks++;
        if (bus_if.jmp !== 1'b1) begin failures++; $display("FAIL jmp_hold_low_phase: got jmp=%b required 1", bus_if.jmp); end
        step(OP_JMP, 0);
        checks++;
        if (bus_if.jmp !== 1'b1) begin failures++; $display("FAIL jmp_back_to_back: got jmp=%b required 1", bus_if.jmp); end
        to_low();
        step(OP_STO, 0); to_low();
        checks++;
        if (bus_if.write !== 1'b0) begin failures++; $display("FAIL sto_b2b_low: got write=%b required 0", bus_if.write); end
        step(OP_STO, 0);
        checks++;
        if (bus_if.write !== 1'b1) begin failures++; $display("FAIL sto_b2b_high: got write=%b required 1", bus_if.write); end
        to_low();
    endtask

    task automatic test_disables();
        step(OP_LDC, 0); to_low();
        step(OP_IEN, 0); to_low();
        step(OP_OEN, 0); to_low();
        step(OP_STO, 0);
        checks++;
        if (bus_if.write !== 1'b0) begin failures++; $display("FAIL oen0_sto: got write=%b required 0", bus_if.write); end
        to_low();
        step(OP_STOC, 0);
        checks++;
        if (bus_if.write !== 1'b0) begin failures++; $display("FAIL oen0_stoc: got write=%b required 0", bus_if.write); end
        to_low();
        step(OP_LD, 1);
        checks++;
        if (bus_if.rr !== 1'b0) begin failures++; $display("FAIL ien0_ld: got rr=%b required 0", bus_if.rr); end
        to_low();
    endtask

    task automatic test_async_reset();
        step(OP_IEN, 1); to_low();
        step(OP_LD, 1); to_low();
        step(OP_JMP, 0);
        rst_n = 0;
        #1;
        checks++;
        if (bus_if.jmp !== 1'b0 || bus_if.rr !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got jmp=%b rr=%b required 0 0", bus_if.jmp, bus_if.rr);
        end
        model_reset();
        to_low();
        rst_n = 1;
        step(OP_LD, 1);
        checks++;
        if (bus_if.rr !== 1'b0) begin failures++; $display("FAIL ien_cleared_by_reset: got rr=%b required 0", bus_if.rr); end
        to_low();
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic       din;
        for (int n = 0; n < 400; n++) begin
            op  = 4'($urandom_range(0, 15));
            din = 1'($urandom_range(0, 1));
            step(op, din);
            checks++;
            if ({bus_if.rr, bus_if.jmp, bus_if.rtn, bus_if.flag_o, bus_if.flag_f, bus_if.write}
                !== {m_rr, e_jmp, e_rtn, e_fo, e_ff, e_write}) begin
                failures++;
                $display("FAIL rand[%0d] op=%h din=%b: got rr,jmp,rtn,fo,ff,wr=%b required %b", n, op, din,
                         {bus_if.rr, bus_if.jmp, bus_if.rtn, bus_if.flag_o, bus_if.flag_f, bus_if.write},
                         {m_rr, e_jmp, e_rtn, e_fo, e_ff, e_write});
            end
            if (e_write) begin
                checks++;
                if (bus_if.data_out !== e_dout) begin
                    failures++;
                    $display("FAIL rand_dout[%0d]: got %b required %b", n, bus_if.data_out, e_dout);
                end
            end
`ifdef MC14500_IR_OUT_EN
            checks++;
            if (bus_if.ir !== m_ir) begin
                failures++;
                $display("FAIL rand_ir[%0d]: got %h required %h", n, bus_if.ir, m_ir);
            end
`endif
            to_low();
            checks++;
            if (bus_if.write !== 1'b0) begin
                failures++;
                $display("FAIL rand_write_low[%0d]: got %b required 0", n, bus_if.write);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_logic();
        test_store();
        test_branch();
        test_skip();
        test_back_to_back();
        test_disables();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/caravel_mc14500.md
# caravel_mc14500

MC14500-compatible 1-bit industrial control unit (ICU) user macro for the Caravel user project area. It executes one 4-bit opcode per clock against a 1-bit result register (RR) and a 1-bit data bus, and drives the classic strobes WRITE, JMP, RTN, FLAG_O and FLAG_F to GPIO. Program memory, the program counter and the I/O selection are external to the block.

## Interface
No parameters.
- clk  in  1  system clock; the active (execute) edge is the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  4  opcode, sampled on the rising clk edge.
- data_in  in  1  data bus input, sampled on the rising clk edge.
- data_out  out  1  store data, valid while write is high.
- write  out  1  store strobe; also the pad output-enable for data_out.
- rr  out  1  result register.
- jmp  out  1  JMP strobe.
- rtn  out  1  RTN strobe.
- flag_o  out  1  NOPO strobe.
- flag_f  out  1  NOPF strobe.

## Operation
- Opcodes:
  - 0 NOPO, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR
  - 8 STO, 9 STOC, 10 IEN, 11 OEN, 12 JMP, 13 RTN, 14 SKZ, 15 NOPF
- Effective data: d = data_in & ien.
- Result-register updates:
  - LD: RR=d. LDC: RR=~d.
  - AND: RR&=d. ANDC: RR&=~d.
  - OR: RR|=d. ORC: RR|=~d.
  - XNOR: RR = (RR==d).
- IEN: ien <= data_in (raw, unmasked). OEN: oen <= data_in (raw, unmasked).
- STO / STOC with oen=1: write pulse; data_out = RR (STO) or ~RR (STOC). RR is unchanged. With oen=0 nothing happens.
- JMP, RTN, NOPO, NOPF: assert jmp, rtn, flag_o or flag_f respectively for one cycle.
- SKZ: sets skip if RR==0.
- RTN: also sets skip unconditionally.
- Skip: when set, the next fetched instruction is suppressed. It is treated as a NOP that raises no strobes and changes no state. Skip then clears.
- Reset: rr=0, ien=0, oen=0, skip=0, all strobes 0, data_out=0.

## Timing
- Execute edge is the rising clk edge, and RR updates on that same edge.
- Result visibility: RR is valid by the following falling edge. Each instruction has 1-cycle latency.
- jmp, rtn, flag_o, flag_f:
  - registered on the execute edge;
  - held high for exactly one full clk period;
  - deasserted on the next rising edge unless the instruction repeats.
- write:
  - asserted only during the high phase of clk in the execute cycle (registered qualifier ANDed with clk);
  - must be low by the falling edge;
  - data_out is stable for the whole write-high window.
- Back-to-back identical strobe opcodes keep the strobe high continuously. write still returns low each low phase.
- A suppressed (skipped) instruction produces no strobe and no write.
- Reset may assert mid-cycle. All outputs go to reset values immediately and asynchronously; the first execute edge is the first rising clk edge after rst_n rises.

## Configuration
- MC14500_IR_OUT_EN defined:
  - adds output ir[3:0] holding the last executed (non-suppressed) opcode;
  - reset value 4'hF;
  - ir does not change on skipped cycles.
- MC14500_IR_OUT_EN undefined: port and register absent. Functionality is otherwise identical.

## Structure
- mc14500_pkg: 4-bit opcode enum (values as listed).
- One sub-module, mc14500_lu: combinational logic unit.
  - Inputs: opcode, RR, d.
  - Outputs: next RR and data_out value.
- Top level holds: ien, oen, skip, RR, the strobe registers and the write clock gating.

## Test plan
- Reset sequence: release reset, then NOPO, then NOPF -> flag_o=1 and flag_f=0 in the first cycle; flag_f=1 and flag_o=0 in the next cycle.
- Logic operations, with IEN(1) then OEN(1):
  - LD with data 1 then 0 -> RR 1 then 0.
  - LDC with data 0 -> RR=1.
  - ORC with data 0 -> RR=1.
  - ANDC with data 1 -> RR=0.
  - XNOR with RR=1: data 1 -> RR=1; data 0 -> RR=0, then RR=1 on the next cycle.
- Stores: RR=1, STO -> write=1 and data_out=1 in the high phase, write=0 at the falling edge. RR=0, STOC -> data_out=1.
- Branch strobes: JMP -> jmp=1 for one cycle; then RTN -> jmp=0 and rtn=1.
- Skip: RR=1, SKZ, NOPF -> flag_f=1. RR=0, SKZ, NOPF -> flag_f=0.
- Disables: LDC with data 0 (RR=1), IEN(0), OEN(0), then:
  - STO and STOC -> write stays 0;
  - LD with data 1 -> RR=0.
